// File: rtl/mtf_token_packer.sv
// mtf_token_packer: classifies each symbol against the recency table as a
// hit (3-bit slot token) or miss (9-bit literal token), packs tokens
// MSB-first into bytes and queues them in a small output FIFO.
// Optional build macro: MTF_STATS_EN adds saturating hit_count/miss_count.
module mtf_token_packer #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sym_valid,
   input  logic [7:0] data_in,
   input  logic [7:0] tbl_0,
   input  logic [7:0] tbl_1,
   input  logic [7:0] tbl_2,
   input  logic [7:0] tbl_3,
   input  logic [1:0] tbl_valid_0,
   input  logic [1:0] tbl_valid_1,
   input  logic [1:0] tbl_valid_2,
   input  logic [1:0] tbl_valid_3,
   input  logic       flush,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       overflow,
   output logic       busy
`ifdef MTF_STATS_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_nxt, free;

   // Residual bits are kept left-aligned; bits below res_cnt are always zero.
   logic [6:0]    acc, acc_nxt;
   logic [2:0]    res_cnt, res_nxt;
   logic          flush_pend, pend_nxt, ovf_nxt;

   logic          hit;
   logic [1:0]    k;
   logic [15:0]   tok16, win;
   logic [4:0]    tot;
   logic [1:0]    nb, wr_n;
   logic [7:0]    b0, b1;
   logic          rd, hit_acc, miss_acc;

   assign out_valid = (count != '0);
   assign rd        = out_valid & out_ready;
   assign free      = CW'(FIFO_DEPTH) - count + {{PW{1'b0}}, rd};
   assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
   assign busy      = (res_cnt != 3'd0) | out_valid | flush_pend;

   // Lowest-index valid table entry that matches the symbol.
   always_comb begin
      hit = 1'b1;
      k   = 2'd0;
      if (tbl_valid_0 != 2'd0 && tbl_0 == data_in)      k = 2'd0;
      else if (tbl_valid_1 != 2'd0 && tbl_1 == data_in) k = 2'd1;
      else if (tbl_valid_2 != 2'd0 && tbl_2 == data_in) k = 2'd2;
      else if (tbl_valid_3 != 2'd0 && tbl_3 == data_in) k = 2'd3;
      else hit = 1'b0;
   end

   // Append the token below the residual in a 16-bit window and decide writes.
   always_comb begin
      tok16    = hit ? {1'b1, k, 13'd0} : {1'b0, data_in, 7'd0};
      win      = {acc, 9'd0} | (tok16 >> res_cnt);
      tot      = {2'b00, res_cnt} + (hit ? 5'd3 : 5'd9);
      nb       = tot[4:3];
      wr_n     = 2'd0;
      b0       = win[15:8];
      b1       = win[7:0];
      acc_nxt  = acc;
      res_nxt  = res_cnt;
      pend_nxt = flush_pend;
      ovf_nxt  = overflow;
      hit_acc  = 1'b0;
      miss_acc = 1'b0;
      if (sym_valid) begin
         pend_nxt = flush_pend | flush;
         if ({{(CW-2){1'b0}}, nb} > free) begin
            ovf_nxt = 1'b1;
         end else begin
            wr_n     = nb;
            res_nxt  = tot[2:0];
            hit_acc  = hit;
            miss_acc = ~hit;
            case (nb)
               2'd0:    acc_nxt = win[15:9];
               2'd1:    acc_nxt = win[7:1];
               default: acc_nxt = 7'd0;
            endcase
         end
      end else if (flush | flush_pend) begin
         if (res_cnt == 3'd0) begin
            pend_nxt = 1'b0;
         end else if (free != '0) begin
            wr_n     = 2'd1;
            b0       = {acc, 1'b0};
            acc_nxt  = 7'd0;
            res_nxt  = 3'd0;
            pend_nxt = 1'b0;
         end else begin
            pend_nxt = 1'b1;
         end
      end
      count_nxt = count + {{(CW-2){1'b0}}, wr_n} - {{PW{1'b0}}, rd};
   end

   // Control state: pointers, occupancy, residual and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         acc        <= 7'd0;
         res_cnt    <= 3'd0;
         flush_pend <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr + PW'(wr_n);
         rd_ptr     <= rd_ptr + PW'(rd);
         count      <= count_nxt;
         acc        <= acc_nxt;
         res_cnt    <= res_nxt;
         flush_pend <= pend_nxt;
         overflow   <= ovf_nxt;
      end
   end

   // FIFO storage; up to two bytes land per cycle, oldest at wr_ptr.
   always_ff @(posedge clk) begin
      if (wr_n != 2'd0) mem[wr_ptr] <= b0;
      if (wr_n == 2'd2) mem[wr_ptr + PW'(1)] <= b1;
   end

`ifdef MTF_STATS_EN
   // Saturating counters of accepted tokens.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= 16'd0;
         miss_count <= 16'd0;
      end else begin
         if (hit_acc && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
         if (miss_acc && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mtf_token_packer.sv
// Bench for mtf_token_packer: two instances (depth 8 and depth 4) share one
// stimulus stream; a bit-queue/byte-queue model predicts every output.
module tb_mtf_token_packer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, sym_valid, flush, out_ready;
   logic [7:0] data_in;
   logic [7:0] tbl [4];
   logic [1:0] tv  [4];
   logic [7:0] od  [2];
   logic       ov  [2];
   logic       ovf [2];
   logic       bsy [2];
`ifdef MTF_STATS_EN
   logic [15:0] hc [2];
   logic [15:0] mc [2];
`endif

   mtf_token_packer #(.FIFO_DEPTH(8)) u8 (
      .clk(clk), .rst(rst), .sym_valid(sym_valid), .data_in(data_in),
      .tbl_0(tbl[0]), .tbl_1(tbl[1]), .tbl_2(tbl[2]), .tbl_3(tbl[3]),
      .tbl_valid_0(tv[0]), .tbl_valid_1(tv[1]), .tbl_valid_2(tv[2]), .tbl_valid_3(tv[3]),
      .flush(flush), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
      .overflow(ovf[0]), .busy(bsy[0])
`ifdef MTF_STATS_EN
      , .hit_count(hc[0]), .miss_count(mc[0])
`endif
   );

   mtf_token_packer #(.FIFO_DEPTH(4)) u4 (
      .clk(clk), .rst(rst), .sym_valid(sym_valid), .data_in(data_in),
      .tbl_0(tbl[0]), .tbl_1(tbl[1]), .tbl_2(tbl[2]), .tbl_3(tbl[3]),
      .tbl_valid_0(tv[0]), .tbl_valid_1(tv[1]), .tbl_valid_2(tv[2]), .tbl_valid_3(tv[3]),
      .flush(flush), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
      .overflow(ovf[1]), .busy(bsy[1])
`ifdef MTF_STATS_EN
      , .hit_count(hc[1]), .miss_count(mc[1])
`endif
   );

   // Reference model state per instance.
   bit         rq [2][$];
   logic [7:0] fq [2][$];
   logic [7:0] pq [2][$];
   bit         mpend [2];
   bit         movf  [2];
   int         mhits [2];
   int         mmiss [2];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, m, act, exp, $time);
      end
   endtask

   task automatic model_step(input int m, input int depth);
      bit         rd;
      int         free, nb, k;
      bit         hit;
      bit         tok [$];
      logic [7:0] b;
      rd   = (fq[m].size() != 0) && out_ready;
      free = depth - fq[m].size() + (rd ? 1 : 0);
      if (rst) begin
         rq[m].delete(); fq[m].delete();
         movf[m] = 0; mpend[m] = 0; mhits[m] = 0; mmiss[m] = 0;
         return;
      end
      if (rd) void'(fq[m].pop_front());
      if (sym_valid) begin
         hit = 0; k = 0;
         for (int i = 3; i >= 0; i--)
            if (tv[i] != 0 && tbl[i] == data_in) begin hit = 1; k = i; end
         if (hit) begin
            tok.push_back(1'b1); tok.push_back(k[1]); tok.push_back(k[0]);
         end else begin
            tok.push_back(1'b0);
            for (int i = 7; i >= 0; i--) tok.push_back(data_in[i]);
         end
         nb = (rq[m].size() + tok.size()) / 8;
         if (nb > free) movf[m] = 1;
         else begin
            foreach (tok[i]) rq[m].push_back(tok[i]);
            while (rq[m].size() >= 8) begin
               b = 8'h00;
               for (int i = 0; i < 8; i++) b = {b[6:0], rq[m].pop_front()};
               fq[m].push_back(b);
            end
            if (hit) begin if (mhits[m] < 65535) mhits[m]++; end
            else begin if (mmiss[m] < 65535) mmiss[m]++; end
         end
         mpend[m] = mpend[m] | flush;
      end else if (flush || mpend[m]) begin
         if (rq[m].size() == 0) mpend[m] = 0;
         else if (free >= 1) begin
            while (rq[m].size() < 8) rq[m].push_back(1'b0);
            b = 8'h00;
            for (int i = 0; i < 8; i++) b = {b[6:0], rq[m].pop_front()};
            fq[m].push_back(b);
            mpend[m] = 0;
         end else mpend[m] = 1;
      end
   endtask

   // One clock: log sink pops, advance the model, compare after the edge.
   task automatic step();
      for (int m = 0; m < 2; m++) if (ov[m] && out_ready) pq[m].push_back(od[m]);
      model_step(0, 8);
      model_step(1, 4);
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         chk("out_valid", m, ov[m], fq[m].size() != 0);
         chk("out_data", m, od[m], (fq[m].size() != 0) ? fq[m][0] : 8'h00);
         chk("overflow", m, ovf[m], movf[m]);
         chk("busy", m, bsy[m], (rq[m].size() != 0) || (fq[m].size() != 0) || mpend[m]);
`ifdef MTF_STATS_EN
         chk("hit_count", m, hc[m], mhits[m]);
         chk("miss_count", m, mc[m], mmiss[m]);
`endif
      end
   endtask

   task automatic sym(input logic [7:0] d);
      sym_valid = 1; flush = 0; data_in = d;
      step();
   endtask

   task automatic idle(input int n);
      sym_valid = 0; flush = 0;
      repeat (n) step();
   endtask

   task automatic do_flush();
      sym_valid = 0; flush = 1;
      step();
      flush = 0;
   endtask

   task automatic clr_pops();
      pq[0].delete(); pq[1].delete();
   endtask

   initial begin
      rst = 1; sym_valid = 0; flush = 0; out_ready = 0; data_in = 8'h00;
      for (int i = 0; i < 4; i++) begin tbl[i] = 8'h00; tv[i] = 2'd0; end
      step(); step();
      rst = 0;
      chk("rst_out_valid", 0, ov[0], 0);
      chk("rst_busy", 1, bsy[1], 0);

      // Hit tokens: slot 2 -> 110 repeated.
      tbl[0] = 8'h11; tbl[1] = 8'h22; tbl[2] = 8'h33; tbl[3] = 8'h44;
      tv[0] = 2'd1; tv[1] = 2'd2; tv[2] = 2'd3; tv[3] = 2'd1;
      out_ready = 1;
      clr_pops();
      repeat (8) sym(8'h33);
      idle(3);
      chk("hit_nbytes", 0, pq[0].size(), 3);
      chk("hit_byte0", 0, pq[0][0], 8'hDB);
      chk("hit_byte1", 0, pq[0][1], 8'h6D);
      chk("hit_byte2", 0, pq[0][2], 8'hB6);

      // Miss token then flush.
      for (int i = 0; i < 4; i++) tv[i] = 2'd0;
      clr_pops();
      sym(8'hA5);
      do_flush();
      idle(3);
      chk("miss_nbytes", 0, pq[0].size(), 2);
      chk("miss_byte0", 0, pq[0][0], 8'h52);
      chk("miss_byte1", 0, pq[0][1], 8'h80);
      chk("miss_busy_low", 0, bsy[0], 0);

      // Lowest valid index wins; entry 0 matches but is invalid.
      tbl[0] = 8'h07; tbl[1] = 8'h07; tbl[3] = 8'h07; tv[1] = 2'd2; tv[3] = 2'd3;
      clr_pops();
      sym(8'h07);
      do_flush();
      idle(3);
      chk("lowidx_nbytes", 1, pq[1].size(), 1);
      chk("lowidx_byte", 1, pq[1][0], 8'hA0);

      // Backpressure: depth-4 instance drops the fifth miss token.
      for (int i = 0; i < 4; i++) tv[i] = 2'd0;
      out_ready = 0;
      for (int i = 0; i < 5; i++) sym(8'h10 + 8'(i));
      idle(1);
      chk("ovf_small", 1, ovf[1], 1);
      chk("ovf_large", 0, ovf[0], 0);
      out_ready = 1;
      idle(6);
      do_flush();
      idle(4);

      // Seven-bit residual on a full depth-4 FIFO, one pop, then a miss writes two bytes.
      tbl[0] = 8'h5A; tv[0] = 2'd1;
      out_ready = 0;
      repeat (13) sym(8'h5A);
      out_ready = 1;
      idle(1);
      sym(8'hC3);
      chk("two_byte_model_count", 1, fq[1].size(), 4);
      out_ready = 0;
      clr_pops();
      out_ready = 1;
      idle(6);
      for (int m = 0; m < 2; m++) begin
         chk("two_byte_nbytes", m, pq[m].size(), 4);
         chk("two_byte_b0", m, pq[m][0], 8'h24);
         chk("two_byte_b1", m, pq[m][1], 8'h92);
         chk("two_byte_b2", m, pq[m][2], 8'h48);
         chk("two_byte_b3", m, pq[m][3], 8'hC3);
      end

      // Reset mid-stream: five bytes queued and a 3-bit residual on the depth-8 instance.
      out_ready = 0;
      repeat (11) sym(8'h5A);
      do_flush();
      sym(8'h5A);
      chk("pre_rst_busy", 0, bsy[0], 1);
      rst = 1;
      step();
      rst = 0;
      for (int m = 0; m < 2; m++) begin
         chk("rst_mid_valid", m, ov[m], 0);
         chk("rst_mid_busy", m, bsy[m], 0);
         chk("rst_mid_ovf", m, ovf[m], 0);
`ifdef MTF_STATS_EN
         chk("rst_mid_hits", m, hc[m], 0);
         chk("rst_mid_miss", m, mc[m], 0);
`endif
      end

      // Randomized traffic with varying backpressure.
      for (int blk = 0; blk < 15; blk++) begin
         int rdy_pct;
         rdy_pct = $urandom_range(10, 100);
         for (int c = 0; c < 200; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < 4; i++) begin
               tbl[i] = 8'($urandom_range(0, 7));
               tv[i]  = 2'($urandom_range(0, 3));
            end
            sym_valid = ($urandom_range(0, 3) != 0);
            data_in   = 8'($urandom_range(0, 11));
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(1, 100) <= rdy_pct);
            step();
         end
      end
      rst = 0; sym_valid = 0; flush = 0; out_ready = 1;
      idle(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
